// File: rtl/i2c_reg_access.sv
// i2c_reg_access: turns one register read/write request into the command and
// data stream sequence an i2c_master needs, then returns a single response.
// Optional watchdog: define I2C_REG_ACCESS_TIMEOUT_EN to build it; when the
// macro is absent rsp_timeout is tied low and the FSM waits indefinitely.
module i2c_reg_access #(
   parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   output logic       req_ready,
   input  logic       req_write,
   input  logic [6:0] req_dev_addr,
   input  logic [7:0] req_reg_addr,
   input  logic [7:0] req_wdata,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_rdata,
   output logic       rsp_nack,
   output logic       rsp_timeout,
   output logic [6:0] m_axis_cmd_address,
   output logic       m_axis_cmd_start,
   output logic       m_axis_cmd_read,
   output logic       m_axis_cmd_write,
   output logic       m_axis_cmd_write_multiple,
   output logic       m_axis_cmd_stop,
   output logic       m_axis_cmd_valid,
   input  logic       m_axis_cmd_ready,
   output logic [7:0] m_axis_data_tdata,
   output logic       m_axis_data_tvalid,
   output logic       m_axis_data_tlast,
   input  logic       m_axis_data_tready,
   input  logic [7:0] s_axis_data_tdata,
   input  logic       s_axis_data_tvalid,
   input  logic       s_axis_data_tlast,
   output logic       s_axis_data_tready,
   input  logic       master_busy,
   input  logic       master_missed_ack,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, CMD_WR, DATA_REG, DATA_WR, CMD_RD, RD_DATA, WAIT_IDLE, RESP
   } state_t;

   state_t      state_q, state_d;
   logic        write_q, write_d;
   logic [6:0]  dev_addr_q, dev_addr_d;
   logic [7:0]  reg_addr_q, reg_addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        nack_q, nack_d;
   logic        wait_seen_q, wait_seen_d;
   logic        active;
   logic        tmo_hit;
   logic        tmo_flag;
   logic        unused_tlast;

   // Read stream framing is implied by the single-byte read command.
   assign unused_tlast = s_axis_data_tlast;

   // Cycles in which the bus transaction is in flight.
   assign active = (state_q != IDLE) && (state_q != RESP);

`ifdef I2C_REG_ACCESS_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        tmo_flag_q, tmo_flag_d;

   // Hit fires on the cycle whose increment would reach the limit, so RESP
   // appears exactly TIMEOUT_CYCLES cycles after the request is accepted.
   assign tmo_hit  = active && ((tmo_cnt_q + 16'd1) == TIMEOUT_CYCLES);
   assign tmo_flag = tmo_flag_q;

   // Watchdog counter: restarts on accept, counts every in-flight cycle.
   always_comb begin
      tmo_cnt_d  = tmo_cnt_q;
      tmo_flag_d = tmo_flag_q;
      if (state_q == IDLE && req_valid) begin
         tmo_cnt_d  = '0;
         tmo_flag_d = 1'b0;
      end else if (active) begin
         tmo_cnt_d = tmo_cnt_q + 16'd1;
      end
      if (tmo_hit) tmo_flag_d = 1'b1;
   end

   // Watchdog state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_cnt_q  <= '0;
         tmo_flag_q <= 1'b0;
      end else begin
         tmo_cnt_q  <= tmo_cnt_d;
         tmo_flag_q <= tmo_flag_d;
      end
   end
`else
   logic [15:0] unused_tmo_limit;
   assign unused_tmo_limit = TIMEOUT_CYCLES;
   assign tmo_hit  = 1'b0;
   assign tmo_flag = 1'b0;
`endif

   // Next-state and Moore outputs; payloads come only from captured registers
   // so they cannot move while a valid is waiting for its ready.
   always_comb begin
      state_d     = state_q;
      write_d     = write_q;
      dev_addr_d  = dev_addr_q;
      reg_addr_d  = reg_addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      nack_d      = nack_q;
      wait_seen_d = (state_q == WAIT_IDLE);

      req_ready                 = 1'b0;
      rsp_valid                 = 1'b0;
      rsp_rdata                 = 8'h00;
      rsp_nack                  = 1'b0;
      rsp_timeout               = 1'b0;
      m_axis_cmd_address        = 7'h00;
      m_axis_cmd_start          = 1'b0;
      m_axis_cmd_read           = 1'b0;
      m_axis_cmd_write          = 1'b0;
      m_axis_cmd_write_multiple = 1'b0;
      m_axis_cmd_stop           = 1'b0;
      m_axis_cmd_valid          = 1'b0;
      m_axis_data_tdata         = 8'h00;
      m_axis_data_tvalid        = 1'b0;
      m_axis_data_tlast         = 1'b0;
      s_axis_data_tready        = 1'b0;
      busy                      = (state_q != IDLE);

      if (active && master_missed_ack) nack_d = 1'b1;

      case (state_q)
         IDLE: begin
            req_ready          = 1'b1;
            s_axis_data_tready = 1'b1;   // drain stray read bytes
            if (req_valid) begin
               write_d    = req_write;
               dev_addr_d = req_dev_addr;
               reg_addr_d = req_reg_addr;
               wdata_d    = req_wdata;
               rdata_d    = 8'h00;
               nack_d     = 1'b0;
               state_d    = CMD_WR;
            end
         end
         CMD_WR: begin
            m_axis_cmd_valid          = 1'b1;
            m_axis_cmd_address        = dev_addr_q;
            m_axis_cmd_start          = 1'b1;
            m_axis_cmd_write_multiple = 1'b1;
            m_axis_cmd_stop           = write_q;   // reads keep the bus for a repeated start
            if (m_axis_cmd_ready) state_d = DATA_REG;
         end
         DATA_REG: begin
            m_axis_data_tvalid = 1'b1;
            m_axis_data_tdata  = reg_addr_q;
            m_axis_data_tlast  = !write_q;
            if (m_axis_data_tready) state_d = write_q ? DATA_WR : CMD_RD;
         end
         DATA_WR: begin
            m_axis_data_tvalid = 1'b1;
            m_axis_data_tdata  = wdata_q;
            m_axis_data_tlast  = 1'b1;
            if (m_axis_data_tready) state_d = WAIT_IDLE;
         end
         CMD_RD: begin
            m_axis_cmd_valid   = 1'b1;
            m_axis_cmd_address = dev_addr_q;
            m_axis_cmd_start   = 1'b1;
            m_axis_cmd_read    = 1'b1;
            m_axis_cmd_stop    = 1'b1;
            if (m_axis_cmd_ready) state_d = RD_DATA;
         end
         RD_DATA: begin
            s_axis_data_tready = 1'b1;
            if (s_axis_data_tvalid) begin
               rdata_d = s_axis_data_tdata;
               state_d = WAIT_IDLE;
            end
         end
         WAIT_IDLE: begin
            // master_busy lags the last beat, so ignore it in the first cycle.
            if (wait_seen_q && !master_busy) state_d = RESP;
         end
         RESP: begin
            rsp_valid   = 1'b1;
            rsp_rdata   = rdata_q;
            rsp_nack    = nack_q;
            rsp_timeout = tmo_flag;
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Watchdog expiry abandons whatever handshake was pending.
      if (tmo_hit) begin
         m_axis_cmd_valid   = 1'b0;
         m_axis_data_tvalid = 1'b0;
         s_axis_data_tready = 1'b0;
         rdata_d            = rdata_q;
         state_d            = RESP;
      end
   end

   // State and captured-request registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         dev_addr_q  <= '0;
         reg_addr_q  <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         nack_q      <= 1'b0;
         wait_seen_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         write_q     <= write_d;
         dev_addr_q  <= dev_addr_d;
         reg_addr_q  <= reg_addr_d;
         wdata_q     <= wdata_d;
         rdata_q     <= rdata_d;
         nack_q      <= nack_d;
         wait_seen_q <= wait_seen_d;
      end
   end

endmodule

// File: tb/tb_i2c_reg_access.sv
// tb_i2c_reg_access: request table + scoreboard bench with a small i2c_master model.
`timescale 1ns/1ps
module tb_i2c_reg_access;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [6:0] req_dev_addr = '0;
   logic [7:0] req_reg_addr = '0, req_wdata = '0;
   logic       rsp_valid, rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       rsp_nack, rsp_timeout;
   logic [6:0] m_axis_cmd_address;
   logic       m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write;
   logic       m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_valid;
   logic       m_axis_cmd_ready = 1'b1;
   logic [7:0] m_axis_data_tdata;
   logic       m_axis_data_tvalid, m_axis_data_tlast;
   logic       m_axis_data_tready = 1'b1;
   logic [7:0] s_axis_data_tdata = '0;
   logic       s_axis_data_tvalid = 1'b0, s_axis_data_tlast = 1'b0, s_axis_data_tready;
   logic       master_busy = 1'b0, master_missed_ack = 1'b0;
   logic       busy;

   always #5 clk = ~clk;

   i2c_reg_access #(.TIMEOUT_CYCLES(16'd100)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_dev_addr(req_dev_addr), .req_reg_addr(req_reg_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_nack(rsp_nack), .rsp_timeout(rsp_timeout),
      .m_axis_cmd_address(m_axis_cmd_address), .m_axis_cmd_start(m_axis_cmd_start),
      .m_axis_cmd_read(m_axis_cmd_read), .m_axis_cmd_write(m_axis_cmd_write),
      .m_axis_cmd_write_multiple(m_axis_cmd_write_multiple), .m_axis_cmd_stop(m_axis_cmd_stop),
      .m_axis_cmd_valid(m_axis_cmd_valid), .m_axis_cmd_ready(m_axis_cmd_ready),
      .m_axis_data_tdata(m_axis_data_tdata), .m_axis_data_tvalid(m_axis_data_tvalid),
      .m_axis_data_tlast(m_axis_data_tlast), .m_axis_data_tready(m_axis_data_tready),
      .s_axis_data_tdata(s_axis_data_tdata), .s_axis_data_tvalid(s_axis_data_tvalid),
      .s_axis_data_tlast(s_axis_data_tlast), .s_axis_data_tready(s_axis_data_tready),
      .master_busy(master_busy), .master_missed_ack(master_missed_ack), .busy(busy)
   );

   int checks = 0;
   int errors = 0;

   // Beat encoding: bit16 = data beat; cmd {start,read,write,wm,stop,addr}; data {tlast,byte}.
   typedef logic [16:0] beat_t;
   typedef struct packed { logic [7:0] rdata; logic nack; logic tmo; } rsp_t;
   typedef struct {
      logic       wr;
      logic [6:0] dev;
      logic [7:0] rg, wd, sd;
      logic       nack;
      int         busy_n;
      int         hold;
      logic       rnd;
   } vec_t;

   beat_t exp_beats[$];
   rsp_t  rsp_q[$];

   // Bench control, written only by the main sequence.
   logic rand_rdy = 1'b0, hold_cmd_low = 1'b0, inj_nack_en = 1'b0;
   logic tmo_mode = 1'b0, no_slave = 1'b0, cur_wr = 1'b0;
   logic [7:0] slave_byte = '0;
   int busy_len = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic beat_t cmd_beat(input logic [6:0] a, input logic st, input logic rd,
                                      input logic wr, input logic wm, input logic sp);
      return {1'b0, 4'b0000, st, rd, wr, wm, sp, a};
   endfunction

   function automatic beat_t dat_beat(input logic [7:0] d, input logic last);
      return {1'b1, 7'b0000000, last, d};
   endfunction

   task automatic push_beats(input vec_t v);
      exp_beats.push_back(cmd_beat(v.dev, 1'b1, 1'b0, 1'b0, 1'b1, v.wr));
      exp_beats.push_back(dat_beat(v.rg, !v.wr));
      if (v.wr) exp_beats.push_back(dat_beat(v.wd, 1'b1));
      else      exp_beats.push_back(cmd_beat(v.dev, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1));
   endtask

   // i2c_master model: observes handshakes at negedge, drives its outputs just after posedge.
   logic        s_go, s_drop, busy_go, nack_go, cmd_pend, dat_pend;
   logic [11:0] prev_cmd;
   logic [8:0]  prev_dat;
   int          busy_cnt = 0;
   always begin
      @(negedge clk);
      s_go = 1'b0; s_drop = 1'b0; busy_go = 1'b0; nack_go = 1'b0;
      if (rst) begin
         cmd_pend = 1'b0; dat_pend = 1'b0;
      end else begin
         if (m_axis_cmd_valid || m_axis_data_tvalid || rsp_valid)
            chk("one_valid", {31'b0, (int'(m_axis_cmd_valid) + int'(m_axis_data_tvalid) + int'(rsp_valid)) == 1}, 32'd1);
         if (cmd_pend && !tmo_mode)
            chk("cmd_stable", {m_axis_cmd_valid, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
                m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_address}, {1'b1, prev_cmd});
         if (dat_pend && !tmo_mode)
            chk("data_stable", {m_axis_data_tvalid, m_axis_data_tlast, m_axis_data_tdata}, {1'b1, prev_dat});
         cmd_pend = m_axis_cmd_valid && !m_axis_cmd_ready;
         dat_pend = m_axis_data_tvalid && !m_axis_data_tready;
         prev_cmd = {m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
                     m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_cmd_address};
         prev_dat = {m_axis_data_tlast, m_axis_data_tdata};
         if (m_axis_cmd_valid && m_axis_cmd_ready) begin
            if (exp_beats.size() == 0) begin
               checks++; errors++;
               $display("FAIL cmd_extra actual=%h expected=none", prev_cmd);
            end else chk("cmd_beat", cmd_beat(m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read,
                         m_axis_cmd_write, m_axis_cmd_write_multiple, m_axis_cmd_stop), exp_beats.pop_front());
            if (m_axis_cmd_read && !no_slave) s_go = 1'b1;
         end
         if (m_axis_data_tvalid && m_axis_data_tready) begin
            if (exp_beats.size() == 0) begin
               checks++; errors++;
               $display("FAIL data_extra actual=%h expected=none", prev_dat);
            end else chk("data_beat", dat_beat(m_axis_data_tdata, m_axis_data_tlast), exp_beats.pop_front());
            if (!m_axis_data_tlast && inj_nack_en) nack_go = 1'b1;  // pulse lands in DATA_WR
            if (m_axis_data_tlast && cur_wr) busy_go = 1'b1;
         end
         if (s_axis_data_tvalid && s_axis_data_tready) begin
            s_drop = 1'b1;
            if (!cur_wr) busy_go = 1'b1;
         end
      end
      @(posedge clk); #1;
      m_axis_cmd_ready   = hold_cmd_low ? 1'b0 : (rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      m_axis_data_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_drop || rst) s_axis_data_tvalid = 1'b0;
      if (s_go && !rst) begin
         s_axis_data_tvalid = 1'b1;
         s_axis_data_tdata  = slave_byte;
         s_axis_data_tlast  = 1'b1;
      end
      master_missed_ack = nack_go;
      if (busy_go) busy_cnt = busy_len;
      else if (busy_cnt > 0) busy_cnt--;
      master_busy = (busy_cnt != 0);
   end

   task automatic wait_rsp(output int cyc);
      cyc = 0;
      forever begin
         @(negedge clk);
         if (rsp_valid) break;
         chk("req_ready_busy", {31'b0, req_ready}, 32'd0);
         cyc++;
         if (cyc > 1000) begin
            checks++; errors++;
            $display("FAIL rsp_wait actual=no_rsp expected=rsp_valid");
            break;
         end
      end
   endtask

   task automatic run_txn(input vec_t v);
      int   cyc;
      rsp_t e;
      @(negedge clk);
      rand_rdy = v.rnd; busy_len = v.busy_n; slave_byte = v.sd;
      inj_nack_en = v.nack; cur_wr = v.wr;
      @(posedge clk); #1;
      rsp_ready    = (v.hold == 0);
      req_valid    = 1'b1;
      req_write    = v.wr;
      req_dev_addr = v.dev;
      req_reg_addr = v.rg;
      req_wdata    = v.wd;
      push_beats(v);
      e = '{rdata: (v.wr ? 8'h00 : v.sd), nack: v.nack, tmo: 1'b0};
      rsp_q.push_back(e);
      @(negedge clk);
      chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(cyc);
      if (!v.rnd && v.busy_n == 0) chk("latency", cyc, v.wr ? 32'd5 : 32'd6);
      e = rsp_q.pop_front();
      chk("rsp", {rsp_rdata, rsp_nack, rsp_timeout}, e);
      chk("beats_left", exp_beats.size(), 32'd0);
      for (int i = 0; i < v.hold; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("rsp_hold", {rsp_valid, rsp_rdata, rsp_nack, rsp_timeout, req_ready}, {1'b1, e, 1'b0});
      end
      if (v.hold > 0) begin
         @(posedge clk); #1;
         rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(negedge clk);
      chk("rsp_done", {rsp_valid, req_ready, busy, s_axis_data_tready}, 32'b0101);
   endtask

   vec_t vecs[8];

   initial begin
      #3_000_000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "bench time limit");
   end

   initial begin
      int   cyc;
      vec_t rv;
      //            wr    dev    reg    wdata  slave  nack  busy hold rnd
      vecs[0] = '{1'b1, 7'h50, 8'h10, 8'hA5, 8'h00, 1'b0, 0,  0, 1'b0};
      vecs[1] = '{1'b0, 7'h68, 8'h75, 8'h00, 8'h71, 1'b0, 0,  0, 1'b0};
      vecs[2] = '{1'b1, 7'h3C, 8'h01, 8'hFF, 8'h00, 1'b1, 0,  0, 1'b0};
      vecs[3] = '{1'b1, 7'h3C, 8'h02, 8'h00, 8'h00, 1'b0, 0,  0, 1'b0};
      vecs[4] = '{1'b0, 7'h7F, 8'hFF, 8'h00, 8'h00, 1'b0, 4,  0, 1'b0};
      vecs[5] = '{1'b1, 7'h00, 8'h00, 8'h5A, 8'h00, 1'b0, 2, 10, 1'b1};
      vecs[6] = '{1'b0, 7'h21, 8'h42, 8'h00, 8'hC3, 1'b0, 1,  3, 1'b1};
      vecs[7] = '{1'b1, 7'h7F, 8'h80, 8'h01, 8'h00, 1'b0, 3,  0, 1'b0};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ctrl", {req_ready, s_axis_data_tready, busy, m_axis_cmd_valid, m_axis_data_tvalid,
          rsp_valid, rsp_nack, rsp_timeout}, 32'b11000000);
      chk("reset_payload", {m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
          m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_data_tdata, m_axis_data_tlast, rsp_rdata}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_txn(vecs[i]);

      // Reset while stalled in RD_DATA (slave never returns a byte).
      rv = '{1'b0, 7'h11, 8'h22, 8'h00, 8'h00, 1'b0, 0, 0, 1'b0};
      @(negedge clk);
      no_slave = 1'b1; cur_wr = 1'b0; rand_rdy = 1'b0; busy_len = 0; inj_nack_en = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b0;
      req_dev_addr = rv.dev; req_reg_addr = rv.rg;
      push_beats(rv);
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("midrst_beats", exp_beats.size(), 32'd0);
      chk("midrst_ctrl", {req_ready, s_axis_data_tready, busy, m_axis_cmd_valid, m_axis_data_tvalid,
          rsp_valid, rsp_nack, rsp_timeout}, 32'b11000000);
      chk("midrst_payload", {m_axis_cmd_address, m_axis_cmd_start, m_axis_cmd_read, m_axis_cmd_write,
          m_axis_cmd_write_multiple, m_axis_cmd_stop, m_axis_data_tdata, m_axis_data_tlast, rsp_rdata}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; no_slave = 1'b0;
      exp_beats.delete();
      run_txn(vecs[1]);

`ifdef I2C_REG_ACCESS_TIMEOUT_EN
      // Command stream never ready: watchdog must answer after exactly 100 cycles.
      @(negedge clk);
      hold_cmd_low = 1'b1; tmo_mode = 1'b1; cur_wr = 1'b1; rand_rdy = 1'b0; inj_nack_en = 1'b0;
      @(posedge clk); #1;
      rsp_ready = 1'b1; req_valid = 1'b1; req_write = 1'b1;
      req_dev_addr = 7'h2A; req_reg_addr = 8'h33; req_wdata = 8'h44;
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_rsp(cyc);
      chk("tmo_latency", cyc, 32'd100);
      chk("tmo_rsp", {rsp_rdata, rsp_nack, rsp_timeout}, {8'h00, 1'b0, 1'b1});
      @(negedge clk);
      chk("tmo_done", {rsp_valid, req_ready, busy}, 32'b010);
      hold_cmd_low = 1'b0; tmo_mode = 1'b0;
      repeat (2) @(posedge clk);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/i2c_reg_access.md
I2C_REG_ACCESS -- requirements
Module: i2c_reg_access

Interface
REQ-001 Parameter TIMEOUT_CYCLES, 16'd50000, watchdog limit in clk cycles per transaction (used only with the timeout feature, see REQ-030).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid / req_ready  in / out  1  register-access request handshake.
REQ-005 req_write  in  1  1 = register write, 0 = register read.
REQ-006 req_dev_addr  in  7  I2C 7-bit device address.
REQ-007 req_reg_addr / req_wdata  in  8 each  register index and write data.
REQ-008 rsp_valid / rsp_ready  out / in  1  response handshake.
REQ-009 rsp_rdata  out  8  read data; 0 for writes.
REQ-010 rsp_nack / rsp_timeout  out  1 each  missed-ACK seen / watchdog expired.
REQ-011 m_axis_cmd_address  out  7; m_axis_cmd_start/read/write/write_multiple/stop  out  1 each; m_axis_cmd_valid out 1, m_axis_cmd_ready in 1  command stream to i2c_master.
REQ-012 m_axis_data_tdata out 8, tvalid out 1, tlast out 1, tready in 1  write-data stream to i2c_master.
REQ-013 s_axis_data_tdata in 8, tvalid in 1, tlast in 1, tready out 1  read-data stream from i2c_master.
REQ-014 master_busy / master_missed_ack  in  1 each  i2c_master busy and missed_ack.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 States: IDLE, CMD_WR, DATA_REG, DATA_WR, CMD_RD, RD_DATA, WAIT_IDLE, RESP.
REQ-017 IDLE: req_ready=1; on req_valid&req_ready, capture all req_* fields into registers, clear sticky nack, go to CMD_WR.
REQ-018 CMD_WR: cmd_valid=1, address=dev_addr, start=1, write_multiple=1, stop=req_write, others 0; on cmd handshake go to DATA_REG.
REQ-019 DATA_REG: tdata=reg_addr, tvalid=1, tlast=1 for read, 0 for write; on handshake go to DATA_WR (write) or CMD_RD (read).
REQ-020 DATA_WR: tdata=wdata, tvalid=1, tlast=1; on handshake go to WAIT_IDLE.
REQ-021 CMD_RD: cmd_valid=1, start=1 (repeated start), read=1, stop=1, others 0; on handshake go to RD_DATA.
REQ-022 RD_DATA: s_axis_data_tready=1; on handshake capture tdata into rsp_rdata, go to WAIT_IDLE.
REQ-023 WAIT_IDLE: go to RESP on the first cycle master_busy==0 and at least 2 cycles after entering the state.
REQ-024 RESP: rsp_valid=1, outputs stable until rsp_ready; on handshake go to IDLE; rsp_valid high for exactly one cycle when rsp_ready is held high.
REQ-025 Any cycle outside IDLE/RESP with master_missed_ack=1 sets sticky nack; rsp_nack=sticky nack in RESP.
REQ-026 At most one valid/tvalid output asserted per cycle; valid stays asserted until its handshake, with payload unchanged.
REQ-027 s_axis_data_tready=1 in IDLE as well, discarding stray bytes; ready=0 in all other states except RD_DATA.
REQ-028 A new request is accepted no earlier than the cycle after the RESP handshake; minimum request-to-response latency is 5 cycles for writes and 6 for reads, given zero-wait handshakes.

Reset
REQ-029 rst high forces IDLE immediately, including mid-transaction. Reset values: all valid/tvalid=0, req_ready=1, s_axis_data_tready=1, busy=0, rsp_rdata=0, rsp_nack=0, rsp_timeout=0, all cmd/data payloads=0.

Configuration
REQ-030 Macro I2C_REG_ACCESS_TIMEOUT_EN defined: a 16-bit counter clears on request accept and increments every cycle outside IDLE/RESP. When it reaches TIMEOUT_CYCLES, any pending valid is dropped, rsp_timeout=1, rsp_nack is kept as sampled, and the FSM goes to RESP.
REQ-031 Macro undefined: no counter is built, rsp_timeout is tied 0, and the FSM waits indefinitely.

Verification
REQ-032 Write dev 0x50, reg 0x10, data 0xA5, zero waits -> cmd {0x50, start, write_multiple, stop}; data 0x10 (tlast 0), 0xA5 (tlast 1); rsp nack=0, rdata=0.
REQ-033 Read dev 0x68, reg 0x75, slave returns 0x71 -> cmd write_multiple without stop; data 0x75 tlast=1; cmd start+read+stop; rsp rdata=0x71, nack=0.
REQ-034 Write with master_missed_ack pulsed 1 cycle during DATA_WR -> rsp_nack=1; next request has rsp_nack=0.
REQ-035 cmd_ready and tready toggled randomly, rsp_ready held low 10 cycles -> payloads stable while valid is high; exactly one response; req_ready=0 until the RESP handshake.
REQ-036 rst asserted in RD_DATA -> next cycle IDLE, all outputs at reset values; a following read completes correctly.
REQ-037 With TIMEOUT_EN defined, TIMEOUT_CYCLES=100, and cmd_ready held 0 -> rsp_valid with rsp_timeout=1 exactly 100 cycles after request accept.
